// File: rtl/sift_readout_pkg.sv
// Shared types and record geometry for the SIFT result readout engine.
// A record is {kp padded to 24 bits, dir padded to 8 bits, descriptor}.
package sift_readout_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdr0,
        StHdr1,
        StFetch,
        StLoad,
        StSend,
        StDone
    } state_e;

    localparam int unsigned REC_BYTES = 132;
    localparam int unsigned HDR_BYTES = 2;
    localparam int unsigned REC_W     = 1056;

    // Header is the record count, big-endian over two bytes.
    function automatic logic [7:0] hdr_byte(input logic [15:0] cnt, input logic hi);
        return hi ? cnt[15:8] : cnt[7:0];
    endfunction

endpackage

// File: rtl/sift_rec_shifter.sv
// Record serializer: parallel load, shift out MSB byte first, and flag the
// final byte of the record.
module sift_rec_shifter
    import sift_readout_pkg::*;
#(
    parameter int unsigned RecW     = REC_W,
    parameter int unsigned RecBytes = REC_BYTES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            shift,
    input  logic [RecW-1:0] load_data,
    output logic [7:0]      byte_nxt,
    output logic            last
);

    logic [RecW-1:0] shift_q, shift_d;
    logic [7:0]      cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (load) begin
            shift_d = load_data;
            cnt_d   = 8'd0;
        end else if (shift) begin
            shift_d = {shift_q[RecW-9:0], 8'h00};
            cnt_d   = cnt_q + 8'd1;
        end
    end

    // Next top byte lets the parent register dout in the same cycle as the shift.
    assign byte_nxt = shift_d[RecW-1 -: 8];
    assign last     = (cnt_q == 8'(RecBytes - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_q <= '0;
            cnt_q   <= 8'd0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/sift_result_reader.sv
// Streams a header plus kp_count 132-byte keypoint/descriptor records out of
// the KP1/MAIN_ORI/DESC1 RAMs over a valid/ready byte interface.
module sift_result_reader
    import sift_readout_pkg::*;
#(
    parameter int unsigned KP_AW  = 10,
    parameter int unsigned KP_W   = 18,
    parameter int unsigned DIR_W  = 6,
    parameter int unsigned DESC_W = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [KP_AW-1:0]  kp_count,
    output logic              busy,
    output logic              done,
    output logic [KP_AW-1:0]  rd_addr,
    input  logic [KP_W-1:0]   kp_q,
    input  logic [DIR_W-1:0]  dir_q,
    input  logic [DESC_W-1:0] desc_q,
    output logic [7:0]        dout,
    output logic              dout_valid,
    input  logic              dout_ready
);

    state_e             state_q, state_d;
    logic [KP_AW-1:0]   count_q, count_d;
    logic [KP_AW-1:0]   rd_addr_q, rd_addr_d;
    logic [7:0]         dout_q, dout_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               hs;
    logic               last_byte;
    logic               last_rec;
    logic               sh_load;
    logic               sh_shift;
    logic [7:0]         sh_byte_nxt;
    logic [REC_W-1:0]   rec_data;

    assign hs       = valid_q & dout_ready;
    assign last_rec = (rd_addr_q == KP_AW'(count_q - 1'b1));
    assign sh_load  = (state_q == StLoad);
    assign sh_shift = (state_q == StSend) & hs;
    assign rec_data = {{(24 - KP_W){1'b0}}, kp_q, {(8 - DIR_W){1'b0}}, dir_q, desc_q};

    sift_rec_shifter #(
        .RecW     (REC_W),
        .RecBytes (REC_BYTES)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (sh_load),
        .shift     (sh_shift),
        .load_data (rec_data),
        .byte_nxt  (sh_byte_nxt),
        .last      (last_byte)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            count_q   <= '0;
            rd_addr_q <= '0;
            dout_q    <= 8'h00;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rd_addr_q <= rd_addr_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rd_addr_d = rd_addr_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    count_d   = kp_count;
                    rd_addr_d = '0;
                    state_d   = StHdr0;
                end
            end
            StHdr0: if (hs) state_d = StHdr1;
            StHdr1: if (hs) state_d = (count_q != '0) ? StFetch : StDone;
            StFetch: state_d = StLoad;
            StLoad:  state_d = StSend;
            StSend: begin
                if (hs && last_byte) begin
                    if (last_rec) begin
                        state_d = StDone;
                    end else begin
                        rd_addr_d = rd_addr_q + 1'b1;
                        state_d   = StFetch;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so nothing reaches a port combinationally.
    always_comb begin
        dout_d  = 8'h00;
        valid_d = 1'b0;
        busy_d  = (state_d != StIdle) && (state_d != StDone);
        done_d  = (state_d == StDone);
        unique case (state_d)
            StHdr0: begin
                dout_d  = hdr_byte(16'(count_d), 1'b1);
                valid_d = 1'b1;
            end
            StHdr1: begin
                dout_d  = hdr_byte(16'(count_q), 1'b0);
                valid_d = 1'b1;
            end
            StSend: begin
                dout_d  = sh_byte_nxt;
                valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign rd_addr    = rd_addr_q;
    assign dout       = dout_q;
    assign dout_valid = valid_q;

endmodule

// File: tb/tb_sift_result_reader.sv
// Bench for sift_result_reader: RAM model, byte-stream reference built from
// the frame layout, randomized data and backpressure.
module tb_sift_result_reader;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [9:0]     kp_count = '0;
    logic           busy, done, dout_valid;
    logic [9:0]     rd_addr;
    logic [17:0]    kp_q;
    logic [5:0]     dir_q;
    logic [1023:0]  desc_q;
    logic [7:0]     dout;
    logic           dout_ready = 1'b0;

    logic [17:0]    kp_mem   [0:1023];
    logic [5:0]     dir_mem  [0:1023];
    logic [1023:0]  desc_mem [0:1023];

    int             n_checks = 0;
    int             n_errors = 0;
    int             exp_q [$];

    always #10 clk = ~clk;

    sift_result_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .kp_count   (kp_count),
        .busy       (busy),
        .done       (done),
        .rd_addr    (rd_addr),
        .kp_q       (kp_q),
        .dir_q      (dir_q),
        .desc_q     (desc_q),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    // Synchronous RAMs, one cycle read latency.
    always @(posedge clk) begin
        kp_q   <= kp_mem[rd_addr];
        dir_q  <= dir_mem[rd_addr];
        desc_q <= desc_mem[rd_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h @%0t", tag, got, want, $time);
        end
    endtask

    task automatic fill_random(input int n);
        for (int r = 0; r < n; r++) begin
            kp_mem[r]  = 18'($urandom);
            dir_mem[r] = 6'($urandom);
            for (int w = 0; w < 32; w++) desc_mem[r][32*w +: 32] = $urandom;
        end
    endtask

    // Expected frame: 2 header bytes then per record kp(3), dir(1), desc(128).
    task automatic build_exp(input int cnt);
        int kp;
        exp_q.delete();
        exp_q.push_back(cnt / 256);
        exp_q.push_back(cnt % 256);
        for (int r = 0; r < cnt; r++) begin
            kp = int'(kp_mem[r]);
            exp_q.push_back(kp / 65536);
            exp_q.push_back((kp / 256) % 256);
            exp_q.push_back(kp % 256);
            exp_q.push_back(int'(dir_mem[r]));
            for (int b = 0; b < 128; b++) exp_q.push_back(int'(desc_mem[r][1023 - 8*b -: 8]));
        end
    endtask

    // Returns at the negedge where the FSM sits in HDR0.
    task automatic do_start(input int cnt);
        @(negedge clk);
        start    = 1'b1;
        kp_count = 10'(cnt);
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Consume one frame; duty is percent of cycles with ready high.
    task automatic run_frame(input int cnt, input int duty, input int restart_at);
        int   idx = 0;
        int   gap = 0;
        bit   seen_done = 1'b0;
        bit   stalled = 1'b0;
        logic [7:0] prev = 8'h00;
        bit   rdy;
        int   bound = 600 * (cnt + 1) * 4;
        build_exp(cnt);
        do_start(cnt);
        for (int k = 0; k < bound; k++) begin
            rdy = ($urandom_range(99) < 32'(duty));
            dout_ready = rdy;
            if (restart_at >= 0) begin
                if (k == restart_at) begin
                    start    = 1'b1;
                    kp_count = 10'd5;
                end else begin
                    start = 1'b0;
                end
            end
            if (done) begin
                seen_done = 1'b1;
                check_eq("byte_total", idx, exp_q.size());
                check_eq("busy_in_done", busy, 1'b0);
                if (duty >= 100) check_eq("done_cycle", k, 2 + 134 * cnt);
                break;
            end
            check_eq("busy", busy, 1'b1);
            if (!dout_valid) begin
                if (stalled) check_eq("valid_dropped", 0, 1);
                gap++;
                check_eq("rd_addr", rd_addr, (idx - 2) / 132);
                stalled = 1'b0;
            end else begin
                if (gap != 0) check_eq("gap_len", gap, 2);
                gap = 0;
                if (stalled) check_eq("stall_stable", dout, prev);
                if (rdy) begin
                    if (idx < exp_q.size()) check_eq("byte", dout, exp_q[idx]);
                    else check_eq("extra_byte", idx, exp_q.size());
                    idx++;
                end
                stalled = !rdy;
                prev    = dout;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (!seen_done) check_eq("done_timeout", 0, 1);
        @(negedge clk);
        check_eq("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_dout", dout, 8'h00);
        check_eq("rst_valid", dout_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_addr", rd_addr, 10'd0);

        // Header-only frame.
        run_frame(0, 100, -1);

        // Single known record.
        kp_mem[0]  = 18'h2ABCD;
        dir_mem[0] = 6'h15;
        for (int b = 0; b < 128; b++) desc_mem[0][1023 - 8*b -: 8] = 8'(b);
        run_frame(1, 100, -1);

        // Three records, ready high then 30 % backpressure on the same data.
        fill_random(8);
        run_frame(3, 100, -1);
        run_frame(3, 30, -1);

        // Reset during byte 50 of record 0.
        build_exp(2);
        dout_ready = 1'b1;
        do_start(2);
        repeat (54) @(negedge clk);
        check_eq("pre_rst_byte", dout, exp_q[52]);
        rst = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_valid", dout_valid, 1'b0);
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_done", done, 1'b0);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("post_rst_done", done, 1'b0);
            check_eq("post_rst_busy", busy, 1'b0);
        end
        run_frame(2, 50, -1);

        // start with a different count mid-frame must be ignored.
        fill_random(8);
        run_frame(2, 70, 100);

        fill_random(8);
        run_frame(4, 30, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
